rc_sched: RTL and testbench

Round-robin scheduler that shares one resource among N requesters using a one-hot rotating token, the same rotating-bit scheme as the team's ring counter. It arbitrates the request vector, issues a registered one-hot grant, holds it until the owner finishes, and advances the token past the last owner so every requester is served fairly. It sits between requesting blocks and the shared datapath.

---
 rtl/rc_sched.sv | 150 +++++++++++++++
 tb/tb_rc_sched.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rc_sched.sv
// rc_sched: round-robin scheduler sharing one resource among N requesters.
// A one-hot token marks the highest-priority requester. It moves one place
// past the previous owner on every release, so every requester is served in turn.
// After each release the scheduler inserts one dead cycle (GAP) before the next grant.
// Optional feature macro: RC_SCHED_TIMEOUT_EN. When it is defined, a grant is
// forcibly released after MAX_HOLD cycles and timeout_o pulses for one cycle.
module rc_sched #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [N-1:0]         req_i,
    input  logic                 done_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] gnt_id_o,
    output logic                 busy_o,
    output logic [N-1:0]         token_o,
    output logic                 timeout_o
);

    localparam int W = $clog2(N);

    if (N < 2 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : gParamCheck
        $error("rc_sched: N must be >= 2 and MAX_HOLD must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_e;

    state_e         state_q;
    logic [N-1:0]   gnt_q;
    logic [W-1:0]   gntId_q;
    logic [N-1:0]   token_q;

    logic [W-1:0]   tokId;
    logic [W:0]     candSum;
    logic [W-1:0]   cand;
    logic [W-1:0]   winId;
    logic           winFound;
    logic [W-1:0]   nextTokId;
    logic [N-1:0]   relToken;
    logic           relDone;

`ifdef RC_SCHED_TIMEOUT_EN
    logic [7:0]     holdCnt_q;
    logic           timeout_q;
    logic           relTimeout;
`endif

    // Arbitration: scan upward from the token position with wrap-around, and pick the first requester.
    always_comb begin
        tokId = '0;
        for (int i = 0; i < N; i++) begin
            if (token_q[i]) begin
                tokId = W'(i);
            end
        end
        candSum  = '0;
        cand     = '0;
        winId    = '0;
        winFound = |req_i;
        for (int k = N - 1; k >= 0; k--) begin
            candSum = {1'b0, tokId} + (W+1)'(k);
            cand    = (candSum >= (W+1)'(N)) ? W'(candSum - (W+1)'(N)) : candSum[W-1:0];
            if (req_i[cand]) begin
                winId = cand;
            end
        end
    end

    // Release decision for the current owner, and the token value that follows a release.
    always_comb begin
        relDone   = done_i || !req_i[gntId_q];
        nextTokId = (gntId_q == W'(N - 1)) ? '0 : gntId_q + 1'b1;
        relToken  = N'(1) << nextTokId;
`ifdef RC_SCHED_TIMEOUT_EN
        relTimeout = !relDone && (holdCnt_q == 8'(MAX_HOLD));
`endif
    end

    // Scheduler FSM: IDLE and GAP arbitrate; GRANT holds the grant until it is released.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gntId_q   <= '0;
            token_q   <= N'(1);
`ifdef RC_SCHED_TIMEOUT_EN
            holdCnt_q <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef RC_SCHED_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE, GAP: begin
                    if (en_i && winFound) begin
                        state_q   <= GRANT;
                        gnt_q     <= N'(1) << winId;
                        gntId_q   <= winId;
`ifdef RC_SCHED_TIMEOUT_EN
                        holdCnt_q <= 8'd1;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
`ifdef RC_SCHED_TIMEOUT_EN
                    if (relDone || relTimeout) begin
                        state_q   <= GAP;
                        gnt_q     <= '0;
                        token_q   <= relToken;
                        timeout_q <= relTimeout;
                    end else begin
                        holdCnt_q <= holdCnt_q + 8'd1;
                    end
`else
                    if (relDone) begin
                        state_q <= GAP;
                        gnt_q   <= '0;
                        token_q <= relToken;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt_o    = gnt_q;
    assign gnt_id_o = gntId_q;
    assign busy_o   = |gnt_q;
    assign token_o  = token_q;
`ifdef RC_SCHED_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_rc_sched.sv
// tb_rc_sched: randomized self-checking bench for rc_sched (N=4, MAX_HOLD=8).
// A behavioural model tracks the owner, its hold time and the priority position as
// plain integers. Each rising edge it replays the scheduling rules on the
// inputs the DUT sampled. All outputs are compared one unit after every edge.
module tb_rc_sched;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
`ifdef RC_SCHED_TIMEOUT_EN
    localparam bit TimeoutOn = 1'b1;
`else
    localparam bit TimeoutOn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic [1:0]   gntId;
    logic         busy;
    logic [N-1:0] token;
    logic         timeout;

    int checks = 0;
    int errors = 0;

    // Model state: who holds the resource, for how long, and where priority starts.
    bit mHeld;
    int mGntId;
    int mTokPos;
    int mHold;
    bit mTimeout;

    rc_sched #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .en_i     (en),
        .req_i    (req),
        .done_i   (done),
        .gnt_o    (gnt),
        .gnt_id_o (gntId),
        .busy_o   (busy),
        .token_o  (token),
        .timeout_o(timeout)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: observed %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    function automatic int pickWinner(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            int p;
            p = (start + k) % N;
            if (r[p]) return p;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mHeld    = 1'b0;
        mGntId   = 0;
        mTokPos  = 0;
        mHold    = 0;
        mTimeout = 1'b0;
    endtask

    task automatic modelRelease();
        mHeld   = 1'b0;
        mTokPos = (mGntId + 1) % N;
    endtask

    // One rising edge of the scheduling rules applied to the current inputs.
    task automatic modelEdge();
        int w;
        mTimeout = 1'b0;
        if (mHeld) begin
            if (done || !req[mGntId]) begin
                modelRelease();
            end else if (TimeoutOn && mHold == MAX_HOLD) begin
                modelRelease();
                mTimeout = 1'b1;
            end else begin
                mHold++;
            end
        end else if (en) begin
            w = pickWinner(req, mTokPos);
            if (w >= 0) begin
                mHeld  = 1'b1;
                mGntId = w;
                mHold  = 1;
            end
        end
    endtask

    task automatic checkAll(input string phase);
        checkOutput({phase, ".gnt"},     32'(gnt),     mHeld ? (32'd1 << mGntId) : 32'd0);
        checkOutput({phase, ".gnt_id"},  32'(gntId),   32'(mGntId));
        checkOutput({phase, ".busy"},    32'(busy),    32'(mHeld));
        checkOutput({phase, ".token"},   32'(token),   32'd1 << mTokPos);
        checkOutput({phase, ".timeout"}, 32'(timeout), 32'(mTimeout));
    endtask

    task automatic runCycle(input string phase);
        @(posedge clk);
        if (!rst_n) modelReset();
        else        modelEdge();
        #1;
        checkAll(phase);
    endtask

    // Modes: 0 fair rotation, 1 dense random, 2 steady request, 3 dropping requests, 4 enable low.
    task automatic applyStimulus(input string phase, input int mode, input int cycles, input logic [N-1:0] fixedReq);
        for (int c = 0; c < cycles; c++) begin
            case (mode)
                0: begin en = 1'b1; req = '1; done = mHeld && (mHold == 2); end
                1: begin en = ($urandom_range(0, 7) != 0); req = N'($urandom); done = ($urandom_range(0, 3) == 0); end
                2: begin en = 1'b1; req = fixedReq; done = 1'b0; end
                3: begin en = 1'b1; req = N'($urandom); done = 1'b0; end
                default: begin en = 1'b0; req = N'($urandom); done = ($urandom_range(0, 5) == 0); end
            endcase
            runCycle(phase);
        end
    endtask

    // Reset pulled low between edges must clear the outputs without any clock edge.
    task automatic asyncReset();
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("async_rst");
        runCycle("in_rst");
        runCycle("in_rst");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        req   = '1;
        done  = 1'b0;
        modelReset();
        #12;
        checkOutput("rst.gnt",     32'(gnt),     32'd0);
        checkOutput("rst.token",   32'(token),   32'd1);
        checkOutput("rst.busy",    32'(busy),    32'd0);
        checkOutput("rst.timeout", 32'(timeout), 32'd0);
        checkOutput("rst.gnt_id",  32'(gntId),   32'd0);
        rst_n = 1'b1;

        applyStimulus("fair", 0, 24, '0);
        applyStimulus("steady", 2, 70, 4'b0010);
        applyStimulus("en_off", 4, 12, '0);
        applyStimulus("fair", 0, 7, '0);
        asyncReset();
        applyStimulus("after_rst", 0, 10, '0);

        for (int p = 0; p < 40; p++) begin
            int mode;
            logic [N-1:0] fixedReq;
            mode     = $urandom_range(0, 4);
            fixedReq = ($urandom_range(0, 1) == 0) ? (N'(1) << $urandom_range(0, N - 1)) : N'($urandom);
            applyStimulus("random", mode, $urandom_range(10, 50), fixedReq);
            if ($urandom_range(0, 5) == 0) asyncReset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
